// File: rtl/lcd_arbiter.sv
// rtl/lcd_arbiter.sv - round-robin arbiter sharing the lcd write port, with locked bursts.
// Optional busy watchdog enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [9*NUM_REQ-1:0] req_word,
  input  logic [NUM_REQ-1:0]   lock,
  input  logic                 lcd_busy,
  output logic [8:0]           d_out,
  output logic                 data_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 arb_busy,
  output logic                 error
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, owner, rr_idx, rr_cand, take_idx;
  logic               own_valid, rr_found;
  logic               take, finish, release_own, timeout;
  logic [8:0]         words [NUM_REQ];
  int                 rr_k;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign words[g] = req_word[9*g +: 9];
  end

  // Scan downward so the index nearest ptr+1 is written last and wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_k     = 0;
    rr_cand  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      rr_k    = (int'(ptr) + i) % NUM_REQ;
      rr_cand = IDX_W'(rr_k);
      if (req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      tmo_cnt <= '0;
    else if (state_n == ISSUE)
      tmo_cnt <= '0;
    else if (state == WAIT_BUSY || state == WAIT_DONE)
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

  // Selection is held off during the ack cycle so the requester can present its next word.
  always_comb begin
    state_n     = state;
    take        = 1'b0;
    take_idx    = rr_idx;
    finish      = 1'b0;
    release_own = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (own_valid) begin
          if (!lock[owner])
            release_own = 1'b1;
          else if (req[owner] && ack == '0 && !lcd_busy) begin
            take     = 1'b1;
            take_idx = owner;
          end
        end else if (rr_found && ack == '0 && !lcd_busy) begin
          take = 1'b1;
        end
        if (take)
          state_n = ISSUE;
      end
      ISSUE:     state_n = WAIT_BUSY;
      WAIT_BUSY: if (lcd_busy) state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (!lcd_busy) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      default:   state_n = IDLE;
    endcase
`ifdef LCD_ARB_TIMEOUT_EN
    if ((state == WAIT_BUSY || state == WAIT_DONE) &&
        tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      timeout = 1'b1;
      finish  = 1'b0;
      state_n = IDLE;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_out     <= '0;
      grant     <= '0;
      ack       <= '0;
      error     <= 1'b0;
      ptr       <= IDX_W'(NUM_REQ - 1);
      owner     <= '0;
      own_valid <= 1'b0;
    end else begin
      ack   <= '0;
      error <= timeout;
      if (take) begin
        d_out <= words[take_idx];
        grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << take_idx;
        owner <= take_idx;
      end
      if (release_own) begin
        own_valid <= 1'b0;
        grant     <= '0;
      end
      if (finish || timeout) begin
        ack <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
        ptr <= owner;
      end
      // A watchdog abort always drops the lock, even if the owner still holds it.
      if (finish && lock[owner]) begin
        own_valid <= 1'b1;
      end else if (finish || timeout) begin
        own_valid <= 1'b0;
        grant     <= '0;
      end
    end
  end

  assign data_ready = (state == ISSUE);
  assign arb_busy   = (state != IDLE);

endmodule

// File: tb/tb_lcd_arbiter.sv
// tb/tb_lcd_arbiter.sv - scoreboard bench for lcd_arbiter with a simple lcd busy model.
module tb_lcd_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  req, lock, grant, ack;
  logic [17:0] req_word;
  logic        lcd_busy, force_busy, model_busy, model_on;
  logic [8:0]  d_out;
  logic        data_ready, arb_busy, error;

  int vectors = 0, miscompares = 0, strobes = 0, err_seen = 0;
  int busy_delay = 2, busy_len = 10;

  typedef struct { logic [1:0] g; logic [8:0] w; } exp_t;
  exp_t sb[$];

  assign lcd_busy = force_busy | model_busy;

  always #10 clock = ~clock;

  lcd_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_word(req_word), .lock(lock),
    .lcd_busy(lcd_busy), .d_out(d_out), .data_ready(data_ready), .grant(grant),
    .ack(ack), .arb_busy(arb_busy), .error(error)
  );

  always @(negedge clock) begin
    if (reset_n && data_ready) strobes++;
    if (reset_n && error) err_seen++;
  end

  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (model_on && data_ready) begin
        repeat (busy_delay) @(posedge clock);
        #1 model_busy = 1'b1;
        repeat (busy_len) @(posedge clock);
        #1 model_busy = 1'b0;
      end
    end
  end

  task automatic wait_strobe(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clock);
      if (data_ready) ok = 1'b1;
    end
  endtask

  task automatic wait_ack(input int budget, output logic [1:0] a);
    a = 2'b00;
    for (int c = 0; c < budget && a == 2'b00; c++) begin
      @(negedge clock);
      if (ack != 2'b00) a = ack;
    end
  endtask

  task automatic test_reset();
    bit ok; exp_t e; logic [1:0] a;
    reset_n = 1'b0; req = 2'b11; lock = 2'b00; force_busy = 1'b0; model_on = 1'b1;
    req_word = {9'h1B2, 9'h0A1};
    repeat (3) @(negedge clock);
    vectors++;
    if ({d_out, data_ready, grant, ack, arb_busy, error} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: d_out=%h dr=%b grant=%b ack=%b busy=%b err=%b, required all 0",
               d_out, data_ready, grant, ack, arb_busy, error);
    end
    reset_n = 1'b1;
    @(negedge clock);
    vectors++;
    if (grant !== 2'b01 || d_out !== 9'h0A1) begin
      miscompares++;
      $display("FAIL reset_first_grant: grant=%b d_out=%h, required grant=01 d_out=0a1", grant, d_out);
    end
    sb.push_back('{2'b01, 9'h0A1});
    ok = data_ready;
    e = sb.pop_front();
    vectors++;
    if (!ok || d_out !== e.w || grant !== e.g) begin
      miscompares++;
      $display("FAIL reset_strobe0: ok=%0b d_out=%h grant=%b, required d_out=%h grant=%b", ok, d_out, grant, e.w, e.g);
    end
    wait_ack(60, a);
    req[0] = 1'b0;
    vectors++;
    if (a !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_ack0: ack=%b, required 01", a);
    end
    sb.push_back('{2'b10, 9'h1B2});
    wait_strobe(20, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || d_out !== e.w || grant !== e.g) begin
      miscompares++;
      $display("FAIL reset_strobe1: ok=%0b d_out=%h grant=%b, required d_out=%h grant=%b", ok, d_out, grant, e.w, e.g);
    end
    wait_ack(60, a);
    req[1] = 1'b0;
    vectors++;
    if (a !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_ack1: ack=%b, required 10", a);
    end
  endtask

  task automatic test_contention();
    bit ok; exp_t e; logic [1:0] a; int s0;
    s0 = strobes;
    @(negedge clock);
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      if (t % 2 == 0) sb.push_back('{2'b01, 9'h0A1});
      else            sb.push_back('{2'b10, 9'h1B2});
      wait_strobe(20, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || d_out !== e.w || grant !== e.g) begin
        miscompares++;
        $display("FAIL contention_strobe%0d: ok=%0b d_out=%h grant=%b, required d_out=%h grant=%b",
                 t, ok, d_out, grant, e.w, e.g);
      end
      wait_ack(60, a);
      vectors++;
      if (a !== e.g) begin
        miscompares++;
        $display("FAIL contention_ack%0d: ack=%b, required %b", t, a, e.g);
      end
    end
    req = 2'b00;
    vectors++;
    if (strobes - s0 !== 4) begin
      miscompares++;
      $display("FAIL contention_strobe_count: %0d strobes, required 4", strobes - s0);
    end
  endtask

  task automatic test_single();
    bit ok; exp_t e; logic [1:0] a; logic pb1, pb2; int s0;
    s0 = strobes;
    @(negedge clock);
    req_word[8:0] = 9'h138; req[0] = 1'b1;
    sb.push_back('{2'b01, 9'h138});
    wait_strobe(20, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || d_out !== e.w || grant !== e.g) begin
      miscompares++;
      $display("FAIL single_strobe: ok=%0b d_out=%h grant=%b, required d_out=%h grant=%b", ok, d_out, grant, e.w, e.g);
    end
    pb1 = 1'b1; pb2 = 1'b1; a = 2'b00;
    for (int c = 0; c < 60 && a == 2'b00; c++) begin
      @(negedge clock);
      if (ack != 2'b00) a = ack;
      else begin pb2 = pb1; pb1 = lcd_busy; end
    end
    req[0] = 1'b0;
    vectors++;
    if (a !== 2'b01) begin
      miscompares++;
      $display("FAIL single_ack: ack=%b, required 01", a);
    end
    vectors++;
    if (pb1 !== 1'b0 || pb2 !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ack_latency: busy history before ack=%b%b, required 10", pb2, pb1);
    end
    vectors++;
    if (strobes - s0 !== 1) begin
      miscompares++;
      $display("FAIL single_strobe_count: %0d strobes, required 1", strobes - s0);
    end
  endtask

  task automatic test_lock_burst();
    bit ok; exp_t e; logic [1:0] a;
    logic [8:0] burst [3];
    burst[0] = 9'h080; burst[1] = 9'h141; burst[2] = 9'h142;
    @(negedge clock);
    req_word[8:0] = burst[0]; req[0] = 1'b1; lock[0] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      sb.push_back('{2'b01, burst[t]});
      wait_strobe(20, ok);
      if (t == 0) req[1] = 1'b1;
      e = sb.pop_front();
      vectors++;
      if (!ok || d_out !== e.w || grant !== e.g) begin
        miscompares++;
        $display("FAIL lock_strobe%0d: ok=%0b d_out=%h grant=%b, required d_out=%h grant=%b",
                 t, ok, d_out, grant, e.w, e.g);
      end
      wait_ack(60, a);
      vectors++;
      if (a !== 2'b01 || grant !== 2'b01) begin
        miscompares++;
        $display("FAIL lock_ack%0d: ack=%b grant=%b, required ack=01 grant=01", t, a, grant);
      end
      if (t < 2) req_word[8:0] = burst[t+1];
    end
    req[0] = 1'b0; lock[0] = 1'b0;
    sb.push_back('{2'b10, 9'h1B2});
    wait_strobe(20, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || d_out !== e.w || grant !== e.g) begin
      miscompares++;
      $display("FAIL lock_release_strobe: ok=%0b d_out=%h grant=%b, required d_out=%h grant=%b", ok, d_out, grant, e.w, e.g);
    end
    wait_ack(60, a);
    req[1] = 1'b0;
    vectors++;
    if (a !== 2'b10) begin
      miscompares++;
      $display("FAIL lock_release_ack: ack=%b, required 10", a);
    end
  endtask

  task automatic test_busy_preasserted();
    bit ok; exp_t e; logic [1:0] a; int s0, n;
    @(negedge clock);
    force_busy = 1'b1;
    req_word[17:9] = 9'h1C3; req[1] = 1'b1;
    sb.push_back('{2'b10, 9'h1C3});
    s0 = strobes;
    repeat (6) @(negedge clock);
    vectors++;
    if (strobes - s0 !== 0 || grant !== 2'b00 || arb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_hold: strobes=%0d grant=%b arb_busy=%b, required 0 00 0", strobes - s0, grant, arb_busy);
    end
    @(posedge clock);
    #1 force_busy = 1'b0;
    n = 0; ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clock);
      n++;
      if (data_ready) ok = 1'b1;
    end
    e = sb.pop_front();
    vectors++;
    if (!ok || n !== 2 || d_out !== e.w || grant !== e.g) begin
      miscompares++;
      $display("FAIL busy_release_strobe: ok=%0b cycles=%0d d_out=%h grant=%b, required cycles=2 d_out=%h grant=%b",
               ok, n, d_out, grant, e.w, e.g);
    end
    wait_ack(60, a);
    req[1] = 1'b0;
    vectors++;
    if (a !== 2'b10) begin
      miscompares++;
      $display("FAIL busy_ack: ack=%b, required 10", a);
    end
  endtask

`ifdef LCD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; exp_t e; int n; logic hit;
    model_on = 1'b0;
    @(negedge clock);
    req_word[8:0] = 9'h155; req[0] = 1'b1;
    sb.push_back('{2'b01, 9'h155});
    wait_strobe(20, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || d_out !== e.w || grant !== e.g) begin
      miscompares++;
      $display("FAIL timeout_strobe: ok=%0b d_out=%h grant=%b, required d_out=%h grant=%b", ok, d_out, grant, e.w, e.g);
    end
    n = 0; hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clock);
      n++;
      if (error || ack != 2'b00) hit = 1'b1;
    end
    vectors++;
    if (!hit || n !== 17 || error !== 1'b1 || ack !== 2'b01 || arb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse: cycles=%0d error=%b ack=%b arb_busy=%b, required 17 1 01 0", n, error, ack, arb_busy);
    end
    req[0] = 1'b0;
    model_on = 1'b1;
    repeat (3) @(negedge clock);
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_lock_burst();
    test_busy_preasserted();
`ifdef LCD_ARB_TIMEOUT_EN
    test_timeout();
`else
    vectors++;
    if (err_seen !== 0) begin
      miscompares++;
      $display("FAIL error_tied: error pulsed %0d times, required 0", err_seen);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
